// File: rtl/csr_trap_unit_if.sv
// MW-stage handshake between the pipeline and the CSR/trap unit:
// CSR strobes, interrupt lines, read data and the fetch redirect.
interface csr_trap_unit_if #(
    parameter int XLEN = 32
);
    logic            csr_reg_rdMW;
    logic            csr_reg_wrMW;
    logic            is_mret;
    logic            instr_valid_MW;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] pc_MW;
    logic            timer_irq;
    logic            uart_irq;
    logic [XLEN-1:0] csr_rdata;
    logic            epc_taken;
    logic [XLEN-1:0] epc;

    modport master (
        output csr_reg_rdMW, csr_reg_wrMW, is_mret, instr_valid_MW,
        output csr_addr, csr_wdata, pc_MW, timer_irq, uart_irq,
        input  csr_rdata, epc_taken, epc
    );

    modport slave (
        input  csr_reg_rdMW, csr_reg_wrMW, is_mret, instr_valid_MW,
        input  csr_addr, csr_wdata, pc_MW, timer_irq, uart_irq,
        output csr_rdata, epc_taken, epc
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and interrupt/mret sequencer for the MW stage.
// Interrupts are sampled, decided and then redirected on three successive edges.
module csr_trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic          clk_o,
    input  logic          reset,
    csr_trap_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
    localparam logic [11:0] ADDR_NONE    = 12'h000;
    localparam logic [XLEN-1:0] ALIGN4   = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mie_meie_q, mie_meie_d;
    logic            mip_mtip_q, mip_mtip_d;
    logic            mip_meip_q, mip_meip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic            epc_taken_q, epc_taken_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic            irq_pend;
    logic [3:0]      irq_code;
    logic            take_trap;
    logic            take_ret;
    logic [11:0]     wr_sel;
    logic [XLEN-1:0] rd_val;

    // Direct mode jumps to the base; vectored mode adds 4*cause to it.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                    input logic [3:0]      code);
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] offset;
        base        = tvec & ALIGN4;
        offset      = {{(XLEN-6){1'b0}}, code, 2'b00};
        trap_target = tvec[0] ? (base + offset) : base;
    endfunction

    assign irq_pend  = mstatus_mie_q & ((mie_meie_q & mip_meip_q) | (mie_mtie_q & mip_mtip_q));
    assign irq_code  = (mie_meie_q & mip_meip_q) ? 4'd11 : 4'd7;
    assign take_ret  = (state_q == ST_RUN) & bus.is_mret & bus.instr_valid_MW;
    assign take_trap = (state_q == ST_RUN) & irq_pend & bus.instr_valid_MW & ~bus.is_mret;
    // A trapped instruction is squashed, so its CSR write never lands.
    assign wr_sel    = (bus.csr_reg_wrMW & bus.instr_valid_MW & (state_q == ST_RUN) & ~take_trap)
                       ? bus.csr_addr : ADDR_NONE;

    // CSR read mux; the value is the pre-write state of this cycle.
    always_comb begin
        rd_val = '0;
        if (bus.csr_reg_rdMW) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: rd_val = {{(XLEN-8){1'b0}}, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
                ADDR_MIE:     rd_val = {{(XLEN-12){1'b0}}, mie_meie_q, 3'b000, mie_mtie_q, 7'b0000000};
                ADDR_MIP:     rd_val = {{(XLEN-12){1'b0}}, mip_meip_q, 3'b000, mip_mtip_q, 7'b0000000};
                ADDR_MTVEC:   rd_val = mtvec_q;
                ADDR_MEPC:    rd_val = mepc_q;
                ADDR_MCAUSE:  rd_val = mcause_q;
                ADDR_MCYCLE:  rd_val = mcycle_q[31:0];
                ADDR_MCYCLEH: rd_val = mcycle_q[63:32];
                default:      rd_val = '0;
            endcase
        end else begin
            rd_val = '0;
        end
    end

    assign bus.csr_rdata = rd_val;
    assign bus.epc_taken = epc_taken_q;
    assign bus.epc       = epc_q;

    // Next-state: CSR writes first, then trap/mret side effects override them.
    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mip_mtip_d     = bus.timer_irq;
        mip_meip_d     = bus.uart_irq;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        epc_taken_d    = 1'b0;
        epc_d          = '0;

        case (wr_sel)
            ADDR_MSTATUS: begin
                mstatus_mie_d  = bus.csr_wdata[3];
                mstatus_mpie_d = bus.csr_wdata[7];
            end
            ADDR_MIE: begin
                mie_mtie_d = bus.csr_wdata[7];
                mie_meie_d = bus.csr_wdata[11];
            end
            ADDR_MTVEC:   mtvec_d  = {bus.csr_wdata[XLEN-1:2], 1'b0, bus.csr_wdata[0]};
            ADDR_MEPC:    mepc_d   = bus.csr_wdata & ALIGN4;
            ADDR_MCAUSE:  mcause_d = bus.csr_wdata;
            ADDR_MCYCLE:  mcycle_d = {mcycle_q[63:32], bus.csr_wdata[31:0]};
            ADDR_MCYCLEH: mcycle_d = {bus.csr_wdata[31:0], mcycle_q[31:0]};
            default: begin
            end
        endcase

        case (state_q)
            ST_RUN: begin
                if (take_ret) begin
                    state_d        = ST_RET;
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                end else if (take_trap) begin
                    state_d        = ST_TRAP;
                    mepc_d         = bus.pc_MW & ALIGN4;
                    mcause_d       = {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                epc_taken_d = 1'b1;
                epc_d       = trap_target(mtvec_q, mcause_q[3:0]);
                state_d     = ST_RUN;
            end
            ST_RET: begin
                epc_taken_d = 1'b1;
                epc_d       = mepc_q;
                state_d     = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and CSR registers with synchronous reset.
    always_ff @(posedge clk_o) begin
        if (reset) begin
            state_q        <= ST_RUN;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mtvec_q        <= {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= 64'd0;
            epc_taken_q    <= 1'b0;
            epc_q          <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mip_mtip_q     <= mip_mtip_d;
            mip_meip_q     <= mip_meip_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            epc_taken_q    <= epc_taken_d;
            epc_q          <= epc_d;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios followed by random
// traffic, all compared against an architectural model of the CSR/trap rules.
module tb_csr_trap_unit;
    logic clk_o = 1'b0;
    logic reset;

    csr_trap_unit_if #(.XLEN(32)) bus ();

    csr_trap_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk_o (clk_o),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_o = ~clk_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural model state
    bit        m_mie, m_mpie, m_mtie, m_meie, m_mtip, m_meip;
    bit [31:0] m_mtvec, m_mepc, m_mcause;
    bit [63:0] m_cycle;
    int        m_code;
    int        m_redirect;     // 0 none, 1 interrupt entry, 2 mret, decided on the previous edge
    bit        exp_taken;
    bit [31:0] exp_epc;
    bit [31:0] last_rdata;
    bit        last_taken;
    bit [31:0] last_epc;
    bit [31:0] hi_before;

    bit [11:0] addr_tab [0:9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                  12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h301};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_read(input bit rd, input bit [11:0] a);
        bit [31:0] v;
        v = 32'd0;
        if (rd) begin
            case (a)
                12'h300: v = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
                12'h304: v = (32'(m_meie) << 11) | (32'(m_mtie) << 7);
                12'h344: v = (32'(m_meip) << 11) | (32'(m_mtip) << 7);
                12'h305: v = m_mtvec;
                12'h341: v = m_mepc;
                12'h342: v = m_mcause;
                12'hB00: v = m_cycle[31:0];
                12'hB80: v = m_cycle[63:32];
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    // Apply one clock edge of architectural behaviour to the model.
    task automatic model_edge();
        bit        pend, accept, cyc_written, old_mie, old_mpie;
        bit [31:0] wd;
        int        nr;
        exp_taken = (m_redirect != 0) && !reset;
        if (m_redirect == 1)
            exp_epc = (m_mtvec & ~32'd3) + (m_mtvec[0] ? 32'(4 * m_code) : 32'd0);
        else
            exp_epc = m_mepc;
        if (reset) begin
            {m_mie, m_mpie, m_mtie, m_meie, m_mtip, m_meip} = 6'd0;
            m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
            m_cycle = 64'd0; m_redirect = 0; m_code = 0;
            return;
        end
        old_mie  = m_mie;
        old_mpie = m_mpie;
        accept = (m_redirect == 0) && bus.instr_valid_MW;
        pend   = m_mie && ((m_meie && m_meip) || (m_mtie && m_mtip));
        nr = 0;
        if (accept && bus.is_mret) nr = 2;
        else if (accept && pend)   nr = 1;
        cyc_written = 1'b0;
        wd = bus.csr_wdata;
        if (accept && bus.csr_reg_wrMW && nr != 1) begin
            case (bus.csr_addr)
                12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
                12'h304: begin m_mtie = wd[7]; m_meie = wd[11]; end
                12'h305: m_mtvec  = wd & ~32'd2;
                12'h341: m_mepc   = wd & ~32'd3;
                12'h342: m_mcause = wd;
                12'hB00: begin m_cycle[31:0]  = wd; cyc_written = 1'b1; end
                12'hB80: begin m_cycle[63:32] = wd; cyc_written = 1'b1; end
                default: ;
            endcase
        end
        if (nr == 2) begin
            m_mie  = old_mpie;
            m_mpie = 1'b1;
        end
        if (nr == 1) begin
            m_code   = (m_meie && m_meip) ? 11 : 7;
            m_mepc   = bus.pc_MW & ~32'd3;
            m_mcause = 32'h8000_0000 | 32'(m_code);
            m_mpie   = old_mie;
            m_mie    = 1'b0;
        end
        if (!cyc_written) m_cycle = m_cycle + 64'd1;
        m_mtip = bus.timer_irq;
        m_meip = bus.uart_irq;
        m_redirect = nr;
    endtask

    // One cycle: check read data before the edge, redirect outputs after it.
    task automatic step();
        bit [31:0] exp_rd;
        #1;
        exp_rd = model_read(bus.csr_reg_rdMW, bus.csr_addr);
        last_rdata = bus.csr_rdata;
        chk("csr_rdata", bus.csr_rdata, exp_rd);
        model_edge();
        @(posedge clk_o);
        #1;
        last_taken = bus.epc_taken;
        last_epc   = bus.epc;
        chk("epc_taken", {31'd0, bus.epc_taken}, {31'd0, exp_taken});
        if (exp_taken) chk("epc", bus.epc, exp_epc);
        @(negedge clk_o);
    endtask

    task automatic drive(input bit rd, input bit wr, input bit mret, input bit valid,
                         input bit [11:0] a, input bit [31:0] wd, input bit [31:0] pc);
        bus.csr_reg_rdMW   = rd;
        bus.csr_reg_wrMW   = wr;
        bus.is_mret        = mret;
        bus.instr_valid_MW = valid;
        bus.csr_addr       = a;
        bus.csr_wdata      = wd;
        bus.pc_MW          = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 32'd0);
        step();
    endtask

    task automatic rd_csr(input bit [11:0] a);
        drive(1'b1, 1'b0, 1'b0, 1'b0, a, 32'd0, 32'd0);
        step();
    endtask

    task automatic wr_csr(input bit [11:0] a, input bit [31:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b1, a, d, 32'h0000_0010);
        step();
    endtask

    task automatic mret_at(input bit [31:0] pc);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 32'd0, pc);
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.timer_irq = 1'b0;
        bus.uart_irq  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        chk("epc_reset", bus.epc, 32'd0);

        // Reset values and cycle counter
        idle(); idle(); idle();
        rd_csr(12'hB00);  chk("mcycle_since_reset", last_rdata, 32'd3);
        rd_csr(12'h305);  chk("mtvec_reset", last_rdata, 32'h0);
        rd_csr(12'h300);  chk("mstatus_reset", last_rdata, 32'h0);
        rd_csr(12'h7C0);  chk("unimpl_read", last_rdata, 32'h0);

        // External interrupt entry, direct mode
        wr_csr(12'h305, 32'h0000_0100);
        wr_csr(12'h304, 32'h0000_0880);
        wr_csr(12'h300, 32'h0000_0008);
        bus.uart_irq = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd0, 32'h40); step();
        chk("no_trap_before_sample", {31'd0, last_taken}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd0, 32'h40); step();
        idle();
        chk("trap_taken", {31'd0, last_taken}, 32'd1);
        chk("trap_epc_direct", last_epc, 32'h100);
        idle();
        chk("trap_pulse_one_cycle", {31'd0, last_taken}, 32'd0);
        bus.uart_irq = 1'b0;
        rd_csr(12'h341);  chk("mepc_after_trap", last_rdata, 32'h40);
        rd_csr(12'h342);  chk("mcause_ext", last_rdata, 32'h8000_000B);
        rd_csr(12'h300);  chk("mstatus_after_trap", last_rdata, 32'h80);

        // mret with uart pending: return first, trap afterwards
        bus.uart_irq = 1'b1;
        idle();
        mret_at(32'h44);
        idle();
        chk("mret_taken", {31'd0, last_taken}, 32'd1);
        chk("mret_epc", last_epc, 32'h40);
        rd_csr(12'h300);  chk("mstatus_after_mret", last_rdata, 32'h88);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd0, 32'h48); step();
        idle();
        chk("trap_after_return", {31'd0, last_taken}, 32'd1);
        chk("trap_after_return_epc", last_epc, 32'h100);
        mret_at(32'h4C);
        idle();
        // MIE is now 1 with uart pending: mret must still win
        mret_at(32'h48);
        idle();
        chk("mret_wins_epc", last_epc, 32'h48);

        // Interrupt coinciding with a CSR write drops the write
        drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h305, 32'h0000_0300, 32'h80); step();
        idle();
        chk("trap_with_write_taken", {31'd0, last_taken}, 32'd1);
        chk("trap_with_write_epc", last_epc, 32'h100);
        rd_csr(12'h305);  chk("mtvec_write_dropped", last_rdata, 32'h100);

        // Vectored mode, timer interrupt
        bus.uart_irq = 1'b0;
        idle();
        mret_at(32'h84);
        idle();
        wr_csr(12'h305, 32'h0000_0201);
        bus.timer_irq = 1'b1;
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd0, 32'h90); step();
        idle();
        chk("vectored_taken", {31'd0, last_taken}, 32'd1);
        chk("vectored_epc", last_epc, 32'h21C);
        rd_csr(12'h342);  chk("mcause_timer", last_rdata, 32'h8000_0007);

        // mcycle low-half wrap
        bus.timer_irq = 1'b0;
        hi_before = m_cycle[63:32];
        wr_csr(12'hB00, 32'hFFFF_FFFF);
        idle();
        rd_csr(12'hB00);  chk("mcycle_wrapped", last_rdata, 32'h0);
        rd_csr(12'hB80);  chk("mcycleh_carry", last_rdata, hi_before + 32'd1);

        // Reset while in TRAP aborts the pulse
        wr_csr(12'h300, 32'h0000_0008);
        bus.timer_irq = 1'b1;
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd0, 32'hA0); step();
        bus.timer_irq = 1'b0;
        reset = 1'b1;
        idle();
        chk("reset_aborts_pulse", {31'd0, last_taken}, 32'd0);
        reset = 1'b0;
        rd_csr(12'h305);  chk("mtvec_after_reset", last_rdata, 32'h0);
        rd_csr(12'h300);  chk("mstatus_after_reset", last_rdata, 32'h0);
        rd_csr(12'h341);  chk("mepc_after_reset", last_rdata, 32'h0);
        rd_csr(12'h342);  chk("mcause_after_reset", last_rdata, 32'h0);
        rd_csr(12'h304);  chk("mie_after_reset", last_rdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit r_mret, r_wr;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) bus.timer_irq = ~bus.timer_irq;
            if ($urandom_range(0, 9) == 0) bus.uart_irq  = ~bus.uart_irq;
            r_mret = ($urandom_range(0, 11) == 0);
            r_wr   = !r_mret && ($urandom_range(0, 2) == 0);
            drive(1'($urandom_range(0, 1)), r_wr, r_mret, ($urandom_range(0, 3) != 0),
                  addr_tab[$urandom_range(0, 9)], $urandom, $urandom);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
